// File: rtl/wb_stage_regfile_if.sv
// Bundle between the MEM/WB pipeline register, decode and the WB stage / register file.
// Ports:
//   MEM/WB side  : wb_in, mem_r_in, mem_result_in, alu_result_in, reg_dest_in, terminate_in
//   decode reads : rs_addr, rt_addr -> rs_data, rt_data (combinational, bypassed)
//   EX forwarding: fwd_valid, fwd_dest, fwd_data
//   host dump    : halted, dump_valid, dump_addr, dump_data, dump_done, wr_count
// The master modport drives the pipeline and read addresses. The slave modport is the
// WB stage, which returns read data, forwarding information and dump status.
interface wb_stage_regfile_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned AW     = 5
);
  logic              wb_in;
  logic              mem_r_in;
  logic [DATA_W-1:0] mem_result_in;
  logic [DATA_W-1:0] alu_result_in;
  logic [AW-1:0]     reg_dest_in;
  logic              terminate_in;

  logic [AW-1:0]     rs_addr;
  logic [AW-1:0]     rt_addr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;

  logic              fwd_valid;
  logic [AW-1:0]     fwd_dest;
  logic [DATA_W-1:0] fwd_data;

  logic              halted;
  logic              dump_valid;
  logic [AW-1:0]     dump_addr;
  logic [DATA_W-1:0] dump_data;
  logic              dump_done;
  logic [31:0]       wr_count;

  modport master (
    output wb_in, mem_r_in, mem_result_in, alu_result_in, reg_dest_in, terminate_in,
    output rs_addr, rt_addr,
    input  rs_data, rt_data,
    input  fwd_valid, fwd_dest, fwd_data,
    input  halted, dump_valid, dump_addr, dump_data, dump_done, wr_count
  );

  modport slave (
    input  wb_in, mem_r_in, mem_result_in, alu_result_in, reg_dest_in, terminate_in,
    input  rs_addr, rt_addr,
    output rs_data, rt_data,
    output fwd_valid, fwd_dest, fwd_data,
    output halted, dump_valid, dump_addr, dump_data, dump_done, wr_count
  );
endinterface

// File: rtl/wb_stage_regfile.sv
// Write-back stage and architectural register file.
// The stage selects load data or the ALU result, commits it to the register file, and
// bypasses the in-flight write to both decode read ports. It also publishes the write as
// the WB forwarding source for EX. When the program-end marker reaches WB, architectural
// state is frozen. Every register is then streamed out, one per cycle, for the host.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous, active-high reset; it clears registers, counter and dump state
//   bus : wb_stage_regfile_if.slave (see the interface file for the signal groups)
module wb_stage_regfile #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREG   = 32,
  parameter int unsigned AW     = 5
) (
  input logic               clk,
  input logic               rst,
  wb_stage_regfile_if.slave bus
);

  localparam logic [AW-1:0] LastIdx = AW'(NREG - 1);

  typedef enum logic [1:0] {StRun, StDump, StDone} state_e;

  state_e            state_q;
  logic [AW-1:0]     idx_q;
  logic              halted_q;
  logic              dump_valid_q;
  logic              dump_done_q;
  logic [31:0]       wr_count_q;
  logic [DATA_W-1:0] regs_q [NREG];

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [DATA_W-1:0] dump_data;

  // A terminating instruction never writes, even if it carries wb_in.
  // Register r0 is never stored.
  always_comb begin
    wr_data = bus.mem_r_in ? bus.mem_result_in : bus.alu_result_in;
    wr_en   = (state_q == StRun) && bus.wb_in && !bus.terminate_in &&
              (bus.reg_dest_in != '0);
  end

  // The read ports are independent. A read of the register being written this cycle
  // returns the new value, so decode does not stall on a WB hazard.
  always_comb begin
    rs_data = '0;
    if (bus.rs_addr != '0) begin
      if (wr_en && (bus.rs_addr == bus.reg_dest_in)) begin
        rs_data = wr_data;
      end else begin
        rs_data = regs_q[bus.rs_addr];
      end
    end
  end

  always_comb begin
    rt_data = '0;
    if (bus.rt_addr != '0) begin
      if (wr_en && (bus.rt_addr == bus.reg_dest_in)) begin
        rt_data = wr_data;
      end else begin
        rt_data = regs_q[bus.rt_addr];
      end
    end
  end

  // Writes are disabled during the dump, so the storage contents are stable here.
  always_comb begin
    dump_data = '0;
    if (idx_q != '0) begin
      dump_data = regs_q[idx_q];
    end
  end

  // Register file storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[bus.reg_dest_in] <= wr_data;
    end
  end

  // Run / dump / done controller. All status outputs are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StRun;
      idx_q        <= '0;
      halted_q     <= 1'b0;
      dump_valid_q <= 1'b0;
      dump_done_q  <= 1'b0;
      wr_count_q   <= '0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (bus.terminate_in) begin
            state_q      <= StDump;
            idx_q        <= '0;
            halted_q     <= 1'b1;
            dump_valid_q <= 1'b1;
          end else if (wr_en) begin
            wr_count_q <= wr_count_q + 32'd1;
          end
        end
        StDump: begin
          // One beat per cycle with no gaps. The final index hands over to the done state.
          if (idx_q == LastIdx) begin
            state_q      <= StDone;
            dump_valid_q <= 1'b0;
            dump_done_q  <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StDone: begin
          // Only reset leaves this state.
        end
        default: begin
          state_q <= StRun;
        end
      endcase
    end
  end

  always_comb begin
    bus.rs_data    = rs_data;
    bus.rt_data    = rt_data;
    bus.fwd_valid  = wr_en;
    bus.fwd_dest   = bus.reg_dest_in;
    bus.fwd_data   = wr_data;
    bus.halted     = halted_q;
    bus.dump_valid = dump_valid_q;
    bus.dump_addr  = idx_q;
    bus.dump_data  = dump_data;
    bus.dump_done  = dump_done_q;
    bus.wr_count   = wr_count_q;
  end

endmodule

// File: tb/tb_wb_stage_regfile.sv
module tb_wb_stage_regfile;

  logic clk;
  logic rst;

  wb_stage_regfile_if #(.DATA_W(32), .AW(5)) bus ();

  wb_stage_regfile #(.DATA_W(32), .NREG(32), .AW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rs;
    logic [31:0] rt;
    logic        fv;
    logic [4:0]  fd;
    logic [31:0] fdata;
    logic        halted;
    logic        dv;
    logic        dd;
    logic [31:0] wc;
  } exp_t;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } beat_t;

  exp_t  exp_q[$];
  beat_t dump_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the architectural register array plus "beats still to stream".
  logic [31:0] m_regs[32];
  bit          m_halted;
  int          m_left;
  logic [31:0] m_wc;
  bit          m_known;

  // Inputs applied during the previous cycle. The model commits them at the edge.
  bit          p_rst, p_wb, p_mr, p_term;
  logic [31:0] p_mem, p_alu;
  logic [4:0]  p_dest;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a, input bit wen,
                                             input logic [4:0] dest, input logic [31:0] wd);
    if (a == 5'd0) return 32'd0;
    if (wen && a == dest) return wd;
    return m_regs[a];
  endfunction

  task automatic model_update();
    bit wen;
    wen = !m_halted && p_wb && !p_term && (p_dest != 5'd0);
    if (p_rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_halted = 1'b0;
      m_left   = 0;
      m_wc     = 32'd0;
      m_known  = 1'b1;
      dump_q.delete();
    end else if (m_known) begin
      if (!m_halted) begin
        if (p_term) begin
          m_halted = 1'b1;
          m_left   = 32;
          for (int a = 0; a < 32; a++) begin
            beat_t b;
            b.addr = 5'(a);
            b.data = (a == 0) ? 32'd0 : m_regs[a];
            dump_q.push_back(b);
          end
        end else if (wen) begin
          m_regs[p_dest] = p_mr ? p_mem : p_alu;
          m_wc           = m_wc + 32'd1;
        end
      end else if (m_left > 0) begin
        m_left--;
      end
    end
  endtask

  task automatic step(input bit r, input bit wb, input bit mr, input logic [31:0] mem,
                      input logic [31:0] alu, input logic [4:0] dest, input bit term,
                      input logic [4:0] rs, input logic [4:0] rt);
    exp_t        e;
    bit          wen;
    logic [31:0] wd;
    @(posedge clk);
    #1;
    model_update();
    rst               = r;
    bus.wb_in         = wb;
    bus.mem_r_in      = mr;
    bus.mem_result_in = mem;
    bus.alu_result_in = alu;
    bus.reg_dest_in   = dest;
    bus.terminate_in  = term;
    bus.rs_addr       = rs;
    bus.rt_addr       = rt;
    wen      = !m_halted && wb && !term && (dest != 5'd0);
    wd       = mr ? mem : alu;
    e.rs     = model_read(rs, wen, dest, wd);
    e.rt     = model_read(rt, wen, dest, wd);
    e.fv     = wen;
    e.fd     = dest;
    e.fdata  = wd;
    e.halted = m_halted;
    e.dv     = m_halted && (m_left > 0);
    e.dd     = m_halted && (m_left == 0);
    e.wc     = m_wc;
    if (m_known) exp_q.push_back(e);
    p_rst = r; p_wb = wb; p_mr = mr; p_mem = mem; p_alu = alu; p_dest = dest; p_term = term;
  endtask

  task automatic idle(input logic [4:0] rs, input logic [4:0] rt);
    step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, rs, rt);
  endtask

  // Monitor: checks each cycle's expected outputs and each dump beat the DUT presents.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("rs_data", bus.rs_data, e.rs);
      chk("rt_data", bus.rt_data, e.rt);
      chk("fwd_valid", 32'(bus.fwd_valid), 32'(e.fv));
      chk("fwd_dest", 32'(bus.fwd_dest), 32'(e.fd));
      chk("fwd_data", bus.fwd_data, e.fdata);
      chk("halted", 32'(bus.halted), 32'(e.halted));
      chk("dump_valid", 32'(bus.dump_valid), 32'(e.dv));
      chk("dump_done", 32'(bus.dump_done), 32'(e.dd));
      chk("wr_count", bus.wr_count, e.wc);
    end
    if (bus.dump_valid === 1'b1) begin
      if (dump_q.size() == 0) begin
        chk("unexpected_dump_beat", 32'd1, 32'd0);
      end else begin
        beat_t b;
        b = dump_q.pop_front();
        chk("dump_addr", 32'(bus.dump_addr), 32'(b.addr));
        chk("dump_data", bus.dump_data, b.data);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0]  d, a, b;
    logic [31:0] v;
    bit          r, t;
    m_known  = 1'b0;
    m_halted = 1'b0;
    m_left   = 0;
    m_wc     = 32'd0;
    p_rst = 0; p_wb = 0; p_mr = 0; p_term = 0; p_mem = 0; p_alu = 0; p_dest = 0;
    rst = 1'b1;
    bus.wb_in = 0; bus.mem_r_in = 0; bus.mem_result_in = 0; bus.alu_result_in = 0;
    bus.reg_dest_in = 0; bus.terminate_in = 0; bus.rs_addr = 0; bus.rt_addr = 0;

    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 3, 4);
    idle(5, 6);

    // ALU write with a same-cycle bypass, then a read from storage.
    step(0, 1, 0, 32'h0, 32'h1234, 5'd5, 0, 5'd5, 5'd0);
    idle(5, 5);
    // Load-data selection.
    step(0, 1, 1, 32'hDEADBEEF, 32'h1, 5'd7, 0, 5'd7, 5'd5);
    idle(7, 5);
    // A write to r0 is dropped.
    step(0, 1, 0, 32'h0, 32'hFFFF, 5'd0, 0, 5'd0, 5'd0);
    idle(0, 7);
    // Back-to-back writes to one register while both ports read it.
    for (int i = 0; i < 3; i++) step(0, 1, 0, 32'h0, 32'hA, 5'd9, 0, 5'd9, 5'd9);
    idle(9, 9);

    // Fill r1..r31 with i*3, then terminate while carrying a write that must be dropped.
    for (int i = 1; i < 32; i++) step(0, 1, 0, 32'h0, 32'(i * 3), 5'(i), 0, 5'(i), 5'(i - 1));
    step(0, 1, 0, 32'h0, 32'h99, 5'd2, 1, 5'd2, 5'd2);
    for (int i = 0; i < 40; i++) begin
      step(0, 1'($urandom), 1'($urandom), $urandom, $urandom, 5'($urandom),
           1'($urandom), 5'($urandom), 5'($urandom));
    end

    // Reset in the middle of a dump.
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i < 32; i++) step(0, 1, 1, 32'(i + 100), 32'h0, 5'(i), 0, 5'(i), 5'(i));
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 10; i++) idle(5'(i), 5'(31 - i));
    step(1, 1, 0, 32'h0, 32'h77, 5'd3, 1, 5'd3, 5'd4);
    for (int i = 0; i < 32; i++) idle(5'(i), 5'(31 - i));
    step(0, 1, 0, 32'h0, 32'h55, 5'd4, 0, 5'd4, 5'd4);
    idle(4, 3);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      r = m_halted ? ($urandom_range(59) == 0) : ($urandom_range(499) == 0);
      t = ($urandom_range(149) == 0);
      d = 5'($urandom);
      v = $urandom;
      a = ($urandom_range(2) == 0) ? d : 5'($urandom);
      b = ($urandom_range(2) == 0) ? d : 5'($urandom);
      step(r, 1'($urandom_range(3) != 0), 1'($urandom), $urandom, v, d, t, a, b);
    end

    for (int i = 0; i < 40; i++) idle(5'($urandom), 5'($urandom));
    idle(0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("pending_cycle_checks", 32'(exp_q.size()), 32'd0);
    chk("pending_dump_beats", 32'(dump_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
